// File: rtl/ucca_cfg_ctrl_pkg.sv
// Shared types and constants for the UCCA region configuration controller.
// Holds the FSM encoding, register-map offsets, the lock key and the empty-range values.
package ucca_cfg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_ARMED     = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_VIOLATION = 2'd3
  } state_t;

  localparam int          MAX_REGIONS  = 4;
  localparam int          IDX_W        = 2;
  localparam logic [15:0] DEF_LOCK_KEY = 16'hA5A5;
  localparam logic [15:0] EMPTY_MIN    = 16'hFFFF;
  localparam logic [15:0] EMPTY_MAX    = 16'h0000;

  // Word index (byte offset / 2) of the LOCK register; table words sit below it.
  localparam logic [3:0]  WORD_LOCK    = 4'h8;
  localparam logic [16:0] WINDOW_SPAN  = 17'h11;

  function automatic logic region_valid(input logic [15:0] lo, input logic [15:0] hi);
    return lo <= hi;
  endfunction

  function automatic logic in_range(input logic [15:0] lo, input logic [15:0] hi,
                                    input logic [15:0] addr);
    return region_valid(lo, hi) && (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/ucca_cfg_ctrl_if.sv
// Data-bus write port used to program the UCCA region table.
interface ucca_cfg_ctrl_if;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;

  modport master (output data_en, output data_wr, output data_addr, output data_wdata);
  modport slave  (input  data_en, input  data_wr, input  data_addr, input  data_wdata);
endinterface

// File: rtl/ucca_cfg_ctrl_region_match.sv
// Range compare of the program counter against every table entry.
// The lowest-numbered valid region containing the PC wins.
module ucca_region_match
  import ucca_cfg_ctrl_pkg::*;
#(
  parameter int NUM_REGIONS = 4
) (
  input  logic [15:0]                  i_pc,
  input  logic [NUM_REGIONS-1:0][15:0] i_min,
  input  logic [NUM_REGIONS-1:0][15:0] i_max,
  output logic                         o_match_valid,
  output logic [IDX_W-1:0]             o_match_idx
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    o_match_valid = 1'b0;
    o_match_idx   = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (in_range(i_min[i], i_max[i], i_pc)) begin
        o_match_valid = 1'b1;
        o_match_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ucca_cfg_ctrl.sv
// UCCA configuration controller: lockable region table, region selection
// for the monitor, and a fixed-length CPU reset pulse on violations.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  UNLOCKED     | table writable, monitor sees an empty range
//  ARMED        | locked, waiting for the PC to enter a region (comb select)
//  ACTIVE       | PC inside region[sel], outputs held from registered sel
//  VIOLATION    | reset asserted while the hold counter runs down
module ucca_cfg_ctrl
  import ucca_cfg_ctrl_pkg::*;
#(
  parameter logic [15:0] CONF_BASE   = 16'h0160,
  parameter int          NUM_REGIONS = 4,
  parameter int          RESET_HOLD  = 8,
  parameter logic [15:0] LOCK_KEY    = DEF_LOCK_KEY
) (
  input  logic             clk,
  input  logic             system_reset_n,
  ucca_cfg_ctrl_if.slave   bus,
  input  logic [15:0]      pc,
  input  logic             region_reset,
  output logic [15:0]      ucc_min,
  output logic [15:0]      ucc_max,
  output logic             cfg_locked,
  output logic             reset
);

  localparam logic [16:0] WIN_LO    = {1'b0, CONF_BASE};
  localparam logic [16:0] WIN_HI    = WIN_LO + WINDOW_SPAN;
  localparam logic [7:0]  HOLD_LOAD = 8'(RESET_HOLD - 1);

  state_t                       r_state;
  state_t                       w_next;
  logic                         r_locked;
  logic                         r_reset;
  logic [IDX_W-1:0]             r_sel;
  logic [7:0]                   r_cnt;
  logic [NUM_REGIONS-1:0][15:0] r_min;
  logic [NUM_REGIONS-1:0][15:0] r_max;

  logic                         w_in_win;
  logic                         w_cfg_wr;
  logic [3:0]                   w_word;
  logic [1:0]                   w_tab_idx;
  logic                         w_tab_hit;
  logic                         w_tab_wr;
  logic                         w_lock_wr;
  logic                         w_viol;
  logic                         w_in_sel;
  logic                         w_match_valid;
  logic [IDX_W-1:0]             w_match_idx;

  // Address decode; the word index only needs the low bits since the window is 18 bytes.
  assign w_in_win  = ({1'b0, bus.data_addr} >= WIN_LO) && ({1'b0, bus.data_addr} <= WIN_HI);
  assign w_cfg_wr  = bus.data_en && bus.data_wr && w_in_win;
  assign w_word    = bus.data_addr[4:1] - CONF_BASE[4:1];
  assign w_tab_idx = w_word[2:1];
  assign w_tab_hit = !w_word[3] && (int'(w_tab_idx) < NUM_REGIONS);
  assign w_lock_wr = w_cfg_wr && (w_word == WORD_LOCK);
  assign w_tab_wr  = w_cfg_wr && w_tab_hit && !r_locked;

  assign w_viol    = ((r_state == ST_ARMED) || (r_state == ST_ACTIVE)) &&
                     ((w_cfg_wr && r_locked) || region_reset);
  assign w_in_sel  = in_range(r_min[r_sel], r_max[r_sel], pc);

  ucca_region_match #(
    .NUM_REGIONS (NUM_REGIONS)
  ) u_match (
    .i_pc          (pc),
    .i_min         (r_min),
    .i_max         (r_max),
    .o_match_valid (w_match_valid),
    .o_match_idx   (w_match_idx)
  );

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_min <= {NUM_REGIONS{EMPTY_MIN}};
      r_max <= {NUM_REGIONS{EMPTY_MAX}};
    end else if (w_tab_wr) begin
      if (w_word[0]) r_max[w_tab_idx] <= bus.data_wdata;
      else           r_min[w_tab_idx] <= bus.data_wdata;
    end
  end

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) r_state <= ST_UNLOCKED;
    else                 r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_UNLOCKED:  if (w_lock_wr && (bus.data_wdata == LOCK_KEY)) w_next = ST_ARMED;
      ST_ARMED: begin
        if (w_viol)             w_next = ST_VIOLATION;
        else if (w_match_valid) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_viol)             w_next = ST_VIOLATION;
        else if (!w_in_sel)     w_next = ST_ARMED;
      end
      ST_VIOLATION: if (r_cnt == 8'd0) w_next = ST_ARMED;
      default:      w_next = ST_UNLOCKED;
    endcase
  end

  // The lock only ever sets; nothing but system reset clears it.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_locked <= 1'b0;
      r_reset  <= 1'b0;
      r_sel    <= '0;
      r_cnt    <= 8'd0;
    end else begin
      if ((r_state == ST_UNLOCKED) && (w_next == ST_ARMED)) r_locked <= 1'b1;
      r_reset <= (w_next == ST_VIOLATION);
      if ((r_state == ST_ARMED) && w_match_valid) r_sel <= w_match_idx;
      if ((r_state != ST_VIOLATION) && (w_next == ST_VIOLATION)) r_cnt <= HOLD_LOAD;
      else if ((r_state == ST_VIOLATION) && (r_cnt != 8'd0))     r_cnt <= r_cnt - 8'd1;
    end
  end

  always_comb begin
    ucc_min = EMPTY_MIN;
    ucc_max = EMPTY_MAX;
    case (r_state)
      ST_UNLOCKED: begin
        ucc_min = EMPTY_MIN;
        ucc_max = EMPTY_MAX;
      end
      ST_ARMED: begin
        if (w_match_valid) begin
          ucc_min = r_min[w_match_idx];
          ucc_max = r_max[w_match_idx];
        end else begin
          ucc_min = r_min[r_sel];
          ucc_max = r_max[r_sel];
        end
      end
      default: begin
        ucc_min = r_min[r_sel];
        ucc_max = r_max[r_sel];
      end
    endcase
  end

  assign cfg_locked = r_locked;
  assign reset      = r_reset;

endmodule

// File: tb/tb_ucca_cfg_ctrl.sv
// Self-checking bench for ucca_cfg_ctrl: a vector table through a scoreboard
// queue, then hand-written violation, priority and mid-violation reset sequences.
module tb_ucca_cfg_ctrl;
  import ucca_cfg_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        system_reset_n;
  logic [15:0] pc;
  logic        region_reset;
  logic [15:0] ucc_min;
  logic [15:0] ucc_max;
  logic        cfg_locked;
  logic        reset;

  ucca_cfg_ctrl_if bus_if();

  ucca_cfg_ctrl dut (
    .clk            (clk),
    .system_reset_n (system_reset_n),
    .bus            (bus_if),
    .pc             (pc),
    .region_reset   (region_reset),
    .ucc_min        (ucc_min),
    .ucc_max        (ucc_max),
    .cfg_locked     (cfg_locked),
    .reset          (reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] pcv;
    logic        rr;
    logic [15:0] e_min;
    logic [15:0] e_max;
    logic        e_lock;
    logic        e_rst;
    state_t      e_st;
  } vec_t;

  typedef struct {
    logic [15:0] mn;
    logic [15:0] mx;
    logic        lk;
    logic        rs;
    state_t      st;
  } exp_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];
  exp_t sb_q [$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mk(input logic en, input logic wr, input logic [15:0] a,
                              input logic [15:0] d, input logic [15:0] p, input logic rr,
                              input logic [15:0] mn, input logic [15:0] mx,
                              input logic lk, input logic rs, input state_t st);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = a; v.wdata = d; v.pcv = p; v.rr = rr;
    v.e_min = mn; v.e_max = mx; v.e_lock = lk; v.e_rst = rs; v.e_st = st;
    return v;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] pcv, input logic rr);
    bus_if.data_en    = en;
    bus_if.data_wr    = wr;
    bus_if.data_addr  = addr;
    bus_if.data_wdata = wdata;
    pc                = pcv;
    region_reset      = rr;
  endtask

  task automatic next_cycle(input logic en, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] pcv, input logic rr);
    @(posedge clk);
    #1;
    drive(en, wr, addr, wdata, pcv, rr);
    @(negedge clk);
  endtask

  task automatic compare_front(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", name);
      return;
    end
    e = sb_q.pop_front();
    check16({name, ".min"},   ucc_min, e.mn);
    check16({name, ".max"},   ucc_max, e.mx);
    check16({name, ".lock"},  16'(cfg_locked), 16'(e.lk));
    check16({name, ".rst"},   16'(reset), 16'(e.rs));
    check16({name, ".state"}, 16'(dut.r_state), 16'(e.st));
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v.en, v.wr, v.addr, v.wdata, v.pcv, v.rr);
    e.mn = v.e_min; e.mx = v.e_max; e.lk = v.e_lock; e.rs = v.e_rst; e.st = v.e_st;
    sb_q.push_back(e);
    @(negedge clk);
    compare_front(name);
  endtask

  // Counts consecutive high cycles of reset starting from the next cycle; bounded.
  task automatic measure_reset(input logic [15:0] pcv, output int width);
    width = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, pcv, 1'b0);
      if (reset) width++;
      else if (width > 0) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int highs;
    logic rst_c7;
    logic rst_c8;

    vecs[0]  = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[1]  = mk(1, 1, 16'h0160, 16'hE000, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[2]  = mk(1, 1, 16'h0162, 16'hE0FF, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[3]  = mk(1, 1, 16'h0164, 16'hE080, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[4]  = mk(1, 1, 16'h0166, 16'hE1FF, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[5]  = mk(1, 1, 16'h0170, 16'h1111, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[6]  = mk(1, 1, 16'h0168, 16'h3000, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[7]  = mk(1, 1, 16'h016A, 16'h30FF, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[8]  = mk(1, 1, 16'h0171, 16'hA5A5, 16'h0000, 0, 16'hFFFF, 16'h0000, 0, 0, ST_UNLOCKED);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'hE000, 16'hE0FF, 1, 0, ST_ARMED);
    vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 16'h3000, 0, 16'h3000, 16'h30FF, 1, 0, ST_ARMED);
    vecs[11] = mk(0, 0, 16'h0000, 16'h0000, 16'h3050, 0, 16'h3000, 16'h30FF, 1, 0, ST_ACTIVE);
    vecs[12] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h3000, 16'h30FF, 1, 0, ST_ACTIVE);
    vecs[13] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h3000, 16'h30FF, 1, 0, ST_ARMED);
    vecs[14] = mk(0, 0, 16'h0000, 16'h0000, 16'hE080, 0, 16'hE000, 16'hE0FF, 1, 0, ST_ARMED);
    vecs[15] = mk(0, 0, 16'h0000, 16'h0000, 16'hE100, 0, 16'hE000, 16'hE0FF, 1, 0, ST_ACTIVE);
    vecs[16] = mk(0, 0, 16'h0000, 16'h0000, 16'hE100, 0, 16'hE080, 16'hE1FF, 1, 0, ST_ARMED);
    vecs[17] = mk(0, 0, 16'h0000, 16'h0000, 16'hE1FF, 0, 16'hE080, 16'hE1FF, 1, 0, ST_ACTIVE);
    vecs[18] = mk(0, 0, 16'h0000, 16'h0000, 16'hE200, 0, 16'hE080, 16'hE1FF, 1, 0, ST_ACTIVE);
    vecs[19] = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 16'hE000, 16'hE0FF, 1, 0, ST_ARMED);
    vecs[20] = mk(0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 16'hE000, 16'hE0FF, 1, 0, ST_ACTIVE);

    system_reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #2;
    check16("por.min",  ucc_min, 16'hFFFF);
    check16("por.max",  ucc_max, 16'h0000);
    check16("por.lock", 16'(cfg_locked), 16'h0000);
    check16("por.rst",  16'(reset), 16'h0000);
    repeat (2) @(negedge clk);
    system_reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Blocked write while locked: reset pulse, table intact, still locked.
    next_cycle(1'b1, 1'b1, 16'h0164, 16'h1234, 16'hE000, 1'b0);
    check16("lockwr.pre_rst", 16'(reset), 16'h0000);
    measure_reset(16'h0000, w);
    check16("lockwr.width", 16'(w), 16'd8);
    check16("lockwr.locked", 16'(cfg_locked), 16'h0001);
    next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'hE100, 1'b0);
    check16("lockwr.min1_kept", ucc_min, 16'hE080);
    check16("lockwr.max1_kept", ucc_max, 16'hE1FF);

    // Repeated region_reset inside VIOLATION must not stretch the pulse.
    next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'hE100, 1'b1);
    check16("noext.pre_rst", 16'(reset), 16'h0000);
    highs  = 0;
    rst_c7 = 1'b0;
    rst_c8 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'hE100, (c == 0) || (c == 3));
      if (reset) highs++;
      if (c == 7) rst_c7 = reset;
      if (c == 8) rst_c8 = reset;
    end
    check16("noext.highs", 16'(highs), 16'd8);
    check16("noext.c7", 16'(rst_c7), 16'h0001);
    check16("noext.c8", 16'(rst_c8), 16'h0000);

    // Violation and ACTIVE exit in the same cycle: violation wins.
    check16("prio.state_pre", 16'(dut.r_state), 16'(ST_ACTIVE));
    next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    check16("prio.pre_rst", 16'(reset), 16'h0000);
    measure_reset(16'h0000, w);
    check16("prio.width", 16'(w), 16'd8);

    // System reset during VIOLATION aborts the pulse and clears everything.
    next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    repeat (4) next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    check16("abort.rst_before", 16'(reset), 16'h0001);
    system_reset_n = 1'b0;
    #1;
    check16("abort.rst",   16'(reset), 16'h0000);
    check16("abort.min",   ucc_min, 16'hFFFF);
    check16("abort.max",   ucc_max, 16'h0000);
    check16("abort.lock",  16'(cfg_locked), 16'h0000);
    check16("abort.state", 16'(dut.r_state), 16'(ST_UNLOCKED));
    @(negedge clk);
    system_reset_n = 1'b1;
    highs = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      if (reset) highs++;
    end
    check16("abort.no_residual", 16'(highs), 16'd0);
    next_cycle(1'b1, 1'b1, 16'h0170, 16'hA5A5, 16'hE000, 1'b0);
    next_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 16'hE000, 1'b0);
    check16("abort.relock",  16'(cfg_locked), 16'h0001);
    check16("abort.tbl_min", ucc_min, 16'hFFFF);
    check16("abort.tbl_max", ucc_max, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
